// File: rtl/fetch_group_buffer.sv
// ----------------------------------------------------------------------------
// fetch_group_buffer
//
// Decoupling queue between the I-cache fetch stage and pre-decode. Each cycle
// it may accept one fetch group of FETCH_WIDTH lanes. Lanes after the first
// predicted-taken branch are dropped, and the surviving lanes are packed in
// lane order into a circular buffer of DEPTH entries. Up to DECODE_WIDTH
// head-ordered entries are shown downstream every cycle. This lets fetch keep
// running during a pre-decode stall, and it absorbs fetch bubbles and I-cache
// misses.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   flush             drop all buffered instructions; blocks enq/deq this cycle
//   in_valid          per-lane valid of the incoming fetch group
//   in_pc/in_insn     lane PCs / instructions, lane i at [i*W +: W]
//   in_pred_taken     per-lane predicted-taken bit
//   in_pred_addr      per-lane predicted next PC
//   in_ic_hit         I-cache hit for the whole group (a miss is never enqueued)
//   in_ready          room for a full group; based only on the registered count
//   out_valid         lane j holds buffered entry head+j
//   out_pc/out_insn   head-ordered PCs / instructions
//   out_pred_taken    head-ordered prediction bits
//   out_pred_addr     head-ordered predicted next PCs
//   out_ready         consumer takes every asserted out_valid lane
//   occupancy         number of entries held
//   ic_miss_event     one-cycle pulse on the first cycle of an I-cache miss
// ----------------------------------------------------------------------------
module fetch_group_buffer #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int PC_WIDTH     = 32,
  parameter int INSN_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [FETCH_WIDTH-1:0]           in_valid,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]  in_pc,
  input  logic [FETCH_WIDTH*INSN_WIDTH-1:0] in_insn,
  input  logic [FETCH_WIDTH-1:0]           in_pred_taken,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]  in_pred_addr,
  input  logic                             in_ic_hit,
  output logic                             in_ready,
  output logic [DECODE_WIDTH-1:0]          out_valid,
  output logic [DECODE_WIDTH*PC_WIDTH-1:0] out_pc,
  output logic [DECODE_WIDTH*INSN_WIDTH-1:0] out_insn,
  output logic [DECODE_WIDTH-1:0]          out_pred_taken,
  output logic [DECODE_WIDTH*PC_WIDTH-1:0] out_pred_addr,
  input  logic                             out_ready,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy,
  output logic                             ic_miss_event
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Reject parameter sets the pointer arithmetic cannot handle: the pointers
  // wrap by plain overflow, and a full group plus a full decode window must
  // fit at the same time.
  generate
    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < FETCH_WIDTH + DECODE_WIDTH)) begin : g_param_check
      $error("fetch_group_buffer: DEPTH must be a power of two >= FETCH_WIDTH+DECODE_WIDTH");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage. The entries need no reset, because occupancy decides which ones
  // are meaningful. The read is combinational so that an entry shows up on
  // out_* the cycle after its enqueue edge.
  // --------------------------------------------------------------------------
  logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [INSN_WIDTH-1:0] insn_mem  [DEPTH];
  logic                  taken_mem [DEPTH];
  logic [PC_WIDTH-1:0]   addr_mem  [DEPTH];

  // Pointer / count / miss state
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             miss_q_reg, miss_q_next;

  // --------------------------------------------------------------------------
  // Lane filtering and packing.
  // A lane survives if it is valid and no earlier valid lane was predicted
  // taken. The taken lane itself survives. An invalid lane with its taken bit
  // set does not block later lanes, which matters for unaligned fetch groups.
  // Each surviving lane is written at tail + (number of surviving lanes below
  // it), so the packing has no gaps.
  // --------------------------------------------------------------------------
  logic [FETCH_WIDTH-1:0] keep;
  logic                   keep_blocked;
  logic [PTR_W-1:0]       keep_cnt;
  logic [PTR_W-1:0]       wr_idx [FETCH_WIDTH];

  always_comb begin
    keep         = '0;
    keep_blocked = 1'b0;
    keep_cnt     = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i] = tail_reg + keep_cnt;
      keep[i]   = in_valid[i] && !keep_blocked;
      if (keep[i]) begin
        keep_cnt = keep_cnt + PTR_W'(1);
      end
      if (in_valid[i] && in_pred_taken[i]) begin
        keep_blocked = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake decisions
  // --------------------------------------------------------------------------
  logic             any_valid;
  logic             enq;
  logic             deq;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] n_enq;
  logic [CNT_W-1:0] n_deq;

  assign any_valid  = |in_valid;
  // in_ready uses only the registered count. Making it depend on this cycle's
  // dequeue would create a combinational path from out_ready to the fetch
  // stage.
  assign free_slots = CNT_W'(DEPTH) - count_reg;
  assign in_ready   = (free_slots >= CNT_W'(FETCH_WIDTH));

  assign enq   = any_valid && in_ic_hit && in_ready && !flush;
  assign deq   = out_ready && !flush;
  assign n_enq = enq ? CNT_W'(keep_cnt) : '0;
  assign n_deq = !deq ? '0 :
                 (count_reg < CNT_W'(DECODE_WIDTH)) ? count_reg : CNT_W'(DECODE_WIDTH);

  // Miss tracking: miss_q remembers that the previous cycle already presented
  // a missing group. This way a miss that lasts many cycles reports only one
  // event. The flag clears on any hit, on any cycle with no valid lanes, and
  // on flush.
  assign miss_q_next   = !flush && any_valid && !in_ic_hit;
  assign ic_miss_event = any_valid && !in_ic_hit && !miss_q_reg && !flush;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next  = head_reg + PTR_W'(n_deq);
      tail_next  = tail_reg + PTR_W'(n_enq);
      count_next = count_reg + n_enq - n_deq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      miss_q_reg <= 1'b0;
    end else begin
      head_reg   <= head_next;
      tail_reg   <= tail_next;
      count_reg  <= count_next;
      miss_q_reg <= miss_q_next;
    end
  end

  // Up to FETCH_WIDTH write ports. The kept lanes map to distinct slots
  // because keep_cnt increases strictly across them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (enq && keep[i]) begin
        pc_mem[wr_idx[i]]    <= in_pc[i*PC_WIDTH +: PC_WIDTH];
        insn_mem[wr_idx[i]]  <= in_insn[i*INSN_WIDTH +: INSN_WIDTH];
        taken_mem[wr_idx[i]] <= in_pred_taken[i];
        addr_mem[wr_idx[i]]  <= in_pred_addr[i*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output window: lane j shows entry head+j. Flush hides the window in the
  // same cycle, so the consumer never acts on instructions being discarded.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DECODE_WIDTH; gi++) begin : g_out
      logic [PTR_W-1:0] rd_idx;
      assign rd_idx         = head_reg + PTR_W'(gi);
      assign out_valid[gi]  = (CNT_W'(gi) < count_reg) && !flush;
      assign out_pc[gi*PC_WIDTH +: PC_WIDTH]         = pc_mem[rd_idx];
      assign out_insn[gi*INSN_WIDTH +: INSN_WIDTH]   = insn_mem[rd_idx];
      assign out_pred_taken[gi]                      = taken_mem[rd_idx];
      assign out_pred_addr[gi*PC_WIDTH +: PC_WIDTH]  = addr_mem[rd_idx];
    end
  endgenerate

  assign occupancy = count_reg;

endmodule

// File: tb/tb_fetch_group_buffer.sv
module tb_fetch_group_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  in_valid;
  logic [63:0] in_pc;
  logic [63:0] in_insn;
  logic [1:0]  in_pred_taken;
  logic [63:0] in_pred_addr;
  logic        in_ic_hit;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_insn;
  logic [1:0]  out_pred_taken;
  logic [63:0] out_pred_addr;
  logic        out_ready;
  logic [3:0]  occupancy;
  logic        ic_miss_event;

  fetch_group_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn),
    .in_pred_taken(in_pred_taken), .in_pred_addr(in_pred_addr),
    .in_ic_hit(in_ic_hit), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_insn(out_insn),
    .out_pred_taken(out_pred_taken), .out_pred_addr(out_pred_addr),
    .out_ready(out_ready), .occupancy(occupancy), .ic_miss_event(ic_miss_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  tkn;
    logic        hit;
    logic        ordy;
    logic        fl;
    logic [31:0] base;
    logic [3:0]  occ;
    logic        irdy;
    logic [1:0]  ov;
    logic        mev;
    logic [31:0] pc0;
    logic [31:0] pc1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] vld, logic [1:0] tkn, logic hit, logic ordy,
                              logic fl, logic [31:0] base, logic [3:0] occ, logic irdy,
                              logic [1:0] ov, logic mev, logic [31:0] pc0, logic [31:0] pc1);
    vec_t v;
    v.vld = vld; v.tkn = tkn; v.hit = hit; v.ordy = ordy; v.fl = fl; v.base = base;
    v.occ = occ; v.irdy = irdy; v.ov = ov; v.mev = mev; v.pc0 = pc0; v.pc1 = pc1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lane i: pc = base + 4i, insn = pc ^ A5A50000, pred_addr = pc + 0x1000
  task automatic drive(input logic [1:0] vld, input logic [1:0] tkn, input logic hit,
                       input logic ordy, input logic fl, input logic [31:0] base);
    logic [31:0] p;
    in_valid      = vld;
    in_pred_taken = tkn;
    in_ic_hit     = hit;
    out_ready     = ordy;
    flush         = fl;
    for (int i = 0; i < 2; i++) begin
      p = base + 32'(4 * i);
      in_pc[i*32 +: 32]        = p;
      in_insn[i*32 +: 32]      = p ^ 32'hA5A5_0000;
      in_pred_addr[i*32 +: 32] = p + 32'h1000;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q_pc[$];
  logic        q_tk[$];
  logic        mq;

  initial begin
    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    chk("reset_occ",  32'(occupancy), 32'd0);
    chk("reset_ov",   32'(out_valid), 32'd0);
    chk("reset_irdy", 32'(in_ready), 32'd1);
    chk("reset_mev",  32'(ic_miss_event), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // ---------------- table: vld tkn hit ordy fl base | occ irdy ov mev pc0 pc1
    // basic pass-through, occupancy 2 then 0
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 32'h0,    0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 1, 0, 32'h1000, 0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 32'h0,    2, 1, 2'b11, 0, 32'h1000, 32'h1004));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 32'h0,    0, 1, 2'b00, 0, 0, 0));
    // taken on lane 0 drops lane 1
    tbl.push_back(mk(2'b11, 2'b01, 1, 0, 0, 32'h1000, 0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 32'h0,    1, 1, 2'b01, 0, 32'h1000, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 32'h0,    1, 1, 2'b01, 0, 32'h1000, 0));
    // fill to full with out_ready low
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 0, 32'h3000, 0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 0, 32'h3008, 2, 1, 2'b11, 0, 32'h3000, 32'h3004));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 0, 32'h3010, 4, 1, 2'b11, 0, 32'h3000, 32'h3004));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 0, 32'h3018, 6, 1, 2'b11, 0, 32'h3000, 32'h3004));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 0, 32'h3020, 8, 0, 2'b11, 0, 32'h3000, 32'h3004));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 32'h0,    8, 0, 2'b11, 0, 32'h3000, 32'h3004));
    // simultaneous enq/deq at count 6
    tbl.push_back(mk(2'b11, 2'b00, 1, 1, 0, 32'h3020, 6, 1, 2'b11, 0, 32'h3008, 32'h300C));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 32'h0,    6, 1, 2'b11, 0, 32'h3010, 32'h3014));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 32'h0,    4, 1, 2'b11, 0, 32'h3018, 32'h301C));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 32'h0,    2, 1, 2'b11, 0, 32'h3020, 32'h3024));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 32'h0,    0, 1, 2'b00, 0, 0, 0));
    // three-cycle miss then hit
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 32'h4000, 0, 1, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 32'h4000, 0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 32'h4000, 0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 0, 32'h4000, 0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 32'h0,    2, 1, 2'b11, 0, 32'h4000, 32'h4004));
    // new miss after a hit; idle cycle clears the miss flag
    tbl.push_back(mk(2'b11, 2'b00, 0, 1, 0, 32'h5000, 2, 1, 2'b11, 1, 32'h4000, 32'h4004));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 32'h0,    0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 0, 32'h5000, 0, 1, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 32'h0,    0, 1, 2'b00, 0, 0, 0));
    // unaligned group: only lane 1 valid
    tbl.push_back(mk(2'b10, 2'b00, 1, 0, 0, 32'h6000, 0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 32'h0,    1, 1, 2'b01, 0, 32'h6004, 0));
    // taken bit on an invalid lane does not block
    tbl.push_back(mk(2'b10, 2'b01, 1, 0, 0, 32'h7000, 0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 0, 32'h0,    1, 1, 2'b01, 0, 32'h7004, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 32'h0,    0, 1, 2'b00, 0, 0, 0));

    foreach (tbl[k]) begin
      drive(tbl[k].vld, tbl[k].tkn, tbl[k].hit, tbl[k].ordy, tbl[k].fl, tbl[k].base);
      #1;
      chk($sformatf("v%0d_occ", k),  32'(occupancy), 32'(tbl[k].occ));
      chk($sformatf("v%0d_irdy", k), 32'(in_ready), 32'(tbl[k].irdy));
      chk($sformatf("v%0d_ov", k),   32'(out_valid), 32'(tbl[k].ov));
      chk($sformatf("v%0d_mev", k),  32'(ic_miss_event), 32'(tbl[k].mev));
      if (tbl[k].ov[0]) begin
        chk($sformatf("v%0d_pc0", k),   out_pc[31:0], tbl[k].pc0);
        chk($sformatf("v%0d_insn0", k), out_insn[31:0], tbl[k].pc0 ^ 32'hA5A5_0000);
        chk($sformatf("v%0d_addr0", k), out_pred_addr[31:0], tbl[k].pc0 + 32'h1000);
      end
      if (tbl[k].ov[1]) begin
        chk($sformatf("v%0d_pc1", k), out_pc[63:32], tbl[k].pc1);
      end
      step();
    end

    // ---------------- flush with enq and deq requested ----------------
    drive(2'b11, 2'b00, 1, 0, 0, 32'h8000); step();
    drive(2'b11, 2'b00, 1, 0, 0, 32'h8008); step();
    drive(2'b01, 2'b00, 1, 0, 0, 32'h8010); step();
    drive(2'b11, 2'b00, 1, 1, 1, 32'h8020); #1;
    chk("flush_occ_pre", 32'(occupancy), 32'd5);
    chk("flush_ov",      32'(out_valid), 32'd0);
    chk("flush_irdy",    32'(in_ready), 32'd1);
    step();
    drive(2'b00, 2'b00, 1, 0, 0, 32'h0); #1;
    chk("flush_occ_post", 32'(occupancy), 32'd0);
    chk("flush_ov_post",  32'(out_valid), 32'd0);
    drive(2'b11, 2'b00, 1, 0, 0, 32'h9000); step();
    drive(2'b00, 2'b00, 1, 0, 0, 32'h0); #1;
    chk("postflush_occ", 32'(occupancy), 32'd2);
    chk("postflush_pc0", out_pc[31:0], 32'h9000);
    chk("postflush_pc1", out_pc[63:32], 32'h9004);

    // ---------------- asynchronous reset mid-cycle ----------------
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_occ",  32'(occupancy), 32'd0);
    chk("async_rst_ov",   32'(out_valid), 32'd0);
    chk("async_rst_irdy", 32'(in_ready), 32'd1);
    chk("async_rst_mev",  32'(ic_miss_event), 32'd0);
    #2 rst_n = 1'b1;
    step();

    // ---------------- random traffic against a queue model ----------------
    mq = 1'b0;
    for (int c = 0; c < 80; c++) begin
      logic [1:0]  v, t;
      logic        h, o, mirdy, blk;
      logic [31:0] base;
      int          sz;
      v    = 2'($urandom_range(0, 3));
      t    = 2'($urandom_range(0, 3));
      h    = ($urandom_range(0, 7) != 0);
      o    = 1'($urandom_range(0, 1));
      base = 32'h0001_0000 + 32'(c * 8);
      drive(v, t, h, o, 1'b0, base);
      #1;
      sz    = q_pc.size();
      mirdy = ((8 - sz) >= 2);
      chk($sformatf("r%0d_occ", c),  32'(occupancy), 32'(sz));
      chk($sformatf("r%0d_irdy", c), 32'(in_ready), 32'(mirdy));
      chk($sformatf("r%0d_mev", c),  32'(ic_miss_event), 32'((v != 0) && !h && !mq));
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("r%0d_ov%0d", c, j), 32'(out_valid[j]), 32'(j < sz));
        if (j < sz) begin
          chk($sformatf("r%0d_pc%0d", c, j), out_pc[j*32 +: 32], q_pc[j]);
          chk($sformatf("r%0d_tk%0d", c, j), 32'(out_pred_taken[j]), 32'(q_tk[j]));
        end
      end
      // model update: dequeue first (head side), then append kept lanes
      if (o) begin
        for (int j = 0; j < 2 && q_pc.size() > 0; j++) begin
          void'(q_pc.pop_front());
          void'(q_tk.pop_front());
        end
      end
      if ((v != 0) && h && mirdy) begin
        blk = 1'b0;
        for (int i = 0; i < 2; i++) begin
          if (v[i] && !blk) begin
            q_pc.push_back(base + 32'(4 * i));
            q_tk.push_back(t[i]);
          end
          if (v[i] && t[i]) blk = 1'b1;
        end
      end
      mq = (v != 0) && !h;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
